// File: rtl/turn_sequencer.sv
// Two-player turn scheduler: accepts one move per turn, issues the target pixel x to the
// active player, waits for its turn_done, then hands over. Optional WAIT timeout: TURN_TIMEOUT_EN.
module turn_sequencer #(
  parameter int NUM_TILES      = 10,
  parameter int TILE_W         = 64,
  parameter int X_ORIGIN       = 0,
  parameter int TIMEOUT_CYCLES = 1 << 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       move_valid,
  input  logic [2:0] move_steps,
  output logic       move_ready,
  output logic       cur_player,
  output logic [9:0] player1_pos_x,
  output logic       player1_pos_valid,
  input  logic       player1_turn_done,
  output logic [9:0] player2_pos_x,
  output logic       player2_pos_valid,
  input  logic       player2_turn_done,
  output logic [3:0] player1_tile,
  output logic [3:0] player2_tile,
  output logic       game_over,
  output logic       winner,
  output logic       timeout_err
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_SWITCH, S_DONE} state_e;

  localparam logic [3:0] LAST_TILE = 4'(NUM_TILES - 1);

  state_e     state_q, state_d;
  logic       cur_player_q, cur_player_d;
  logic [3:0] p1_tile_q, p1_tile_d, p2_tile_q, p2_tile_d;
  logic [9:0] p1_pos_x_q, p1_pos_x_d, p2_pos_x_q, p2_pos_x_d;
  logic       p1_valid_q, p1_valid_d, p2_valid_q, p2_valid_d;
  logic       move_ready_q, move_ready_d;
  logic       game_over_q, game_over_d;
  logic       winner_q, winner_d;
  logic       timeout_err_q, timeout_err_d;

  logic [3:0] active_tile;
  logic       active_done;
  logic [4:0] tile_sum;
  logic [3:0] new_tile;
  logic [9:0] new_x;

`ifdef TURN_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
    state_d       = state_q;
    cur_player_d  = cur_player_q;
    p1_tile_d     = p1_tile_q;
    p2_tile_d     = p2_tile_q;
    p1_pos_x_d    = p1_pos_x_q;
    p2_pos_x_d    = p2_pos_x_q;
    p1_valid_d    = 1'b0;
    p2_valid_d    = 1'b0;
    game_over_d   = game_over_q;
    winner_d      = winner_q;
    timeout_err_d = 1'b0;
`ifdef TURN_TIMEOUT_EN
    wait_cnt_d    = wait_cnt_q;
`endif

    active_tile = cur_player_q ? p2_tile_q : p1_tile_q;
    active_done = cur_player_q ? player2_turn_done : player1_turn_done;
    tile_sum    = {1'b0, active_tile} + {2'b00, move_steps};
    new_tile    = (tile_sum >= {1'b0, LAST_TILE}) ? LAST_TILE : tile_sum[3:0];
    new_x       = 10'(X_ORIGIN + int'(new_tile) * TILE_W);

    unique case (state_q)
      // move_ready is high only in IDLE, so move_valid here is the full handshake
      S_IDLE: begin
        if (move_valid) begin
          if (move_steps != 3'd0) begin
            if (cur_player_q) begin
              p2_tile_d  = new_tile;
              p2_pos_x_d = new_x;
              p2_valid_d = 1'b1;
            end else begin
              p1_tile_d  = new_tile;
              p1_pos_x_d = new_x;
              p1_valid_d = 1'b1;
            end
            state_d = S_ISSUE;
          end else begin
            state_d = S_SWITCH;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef TURN_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      S_WAIT: begin
        if (active_done) begin
          state_d = S_SWITCH;
`ifdef TURN_TIMEOUT_EN
        end else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = S_SWITCH;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
`endif
        end
      end
      S_SWITCH: begin
        if (active_tile == LAST_TILE) begin
          game_over_d = 1'b1;
          winner_d    = cur_player_q;
          state_d     = S_DONE;
        end else begin
          cur_player_d = ~cur_player_q;
          state_d      = S_IDLE;
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    move_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q       <= S_IDLE;
      cur_player_q  <= 1'b0;
      p1_tile_q     <= '0;
      p2_tile_q     <= '0;
      p1_pos_x_q    <= 10'(X_ORIGIN);
      p2_pos_x_q    <= 10'(X_ORIGIN);
      p1_valid_q    <= 1'b0;
      p2_valid_q    <= 1'b0;
      move_ready_q  <= 1'b1;
      game_over_q   <= 1'b0;
      winner_q      <= 1'b0;
      timeout_err_q <= 1'b0;
`ifdef TURN_TIMEOUT_EN
      wait_cnt_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cur_player_q  <= cur_player_d;
      p1_tile_q     <= p1_tile_d;
      p2_tile_q     <= p2_tile_d;
      p1_pos_x_q    <= p1_pos_x_d;
      p2_pos_x_q    <= p2_pos_x_d;
      p1_valid_q    <= p1_valid_d;
      p2_valid_q    <= p2_valid_d;
      move_ready_q  <= move_ready_d;
      game_over_q   <= game_over_d;
      winner_q      <= winner_d;
      timeout_err_q <= timeout_err_d;
`ifdef TURN_TIMEOUT_EN
      wait_cnt_q    <= wait_cnt_d;
`endif
    end
  end

  assign move_ready        = move_ready_q;
  assign cur_player        = cur_player_q;
  assign player1_pos_x     = p1_pos_x_q;
  assign player2_pos_x     = p2_pos_x_q;
  assign player1_pos_valid = p1_valid_q;
  assign player2_pos_valid = p2_valid_q;
  assign player1_tile      = p1_tile_q;
  assign player2_tile      = p2_tile_q;
  assign game_over         = game_over_q;
  assign winner            = winner_q;
  assign timeout_err       = timeout_err_q;

endmodule
